regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised integer register file with a per-register scoreboard, replacing the fixed two-entry register pair in the ID stage's registers handler. Provides two combinational read ports, one write port, a reservation port that marks a destination register busy when an instruction issues, and a hardware clear sequencer that zeroes all registers after reset. Register 0 is hardwired to zero. Sits between the decoder (read/reserve) and the writeback path (write/release).

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers; power of two, ≥ 2; AW = $clog2(NREGS)
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; restarts the clear sequence
- ready  out  1  high when the clear sequence is complete and the file accepts traffic
- rs1_addr  in  AW  read port 1 address
- rs2_addr  in  AW  read port 2 address
- rs1_data  out  XLEN  read port 1 data (combinational)
- rs2_data  out  XLEN  read port 2 data (combinational)
- rs1_busy  out  1  scoreboard bit for rs1_addr (combinational)
- rs2_busy  out  1  scoreboard bit for rs2_addr (combinational)
- we  in  1  write enable
- rd_addr  in  AW  write address
- rd_data  in  XLEN  write data
- rsv_en  in  1  reserve request; sets busy bit of rsv_addr
- rsv_addr  in  AW  register to reserve

## Operation
- State machine: CLEAR, READY.
- reset sampled high: state←CLEAR, clear counter←1, all busy bits←0, ready←0. Applies from any state, including mid-clear.
- CLEAR, reset low: reg[cnt]←0, cnt←cnt+1; on the edge that clears reg[NREGS-1], state←READY. Counter does not wrap.
- CLEAR: we and rsv_en ignored; rsN_data forced to 0; rsN_busy forced to 0.
- READY, write: we=1 and rd_addr≠0 → reg[rd_addr]←rd_data and busy[rd_addr]←0 at the edge.
- READY, reserve: rsv_en=1 and rsv_addr≠0 → busy[rsv_addr]←1.
- Same cycle, write and reserve to the same register: data is written, busy ends at 1 (new producer wins).
- Writes and reservations to address 0 are discarded; reg[0] and busy[0] always read as 0.
- Reserving an already-busy register leaves it busy; writing a non-busy register is legal and leaves busy at 0.
- Reads: rsN_data = reg[rsN_addr], rsN_busy = busy[rsN_addr], except where modified by the configuration option.

## Timing
- Reset values: ready=0, all busy bits 0. In CLEAR, rsN_data=0 and rsN_busy=0.
- Clear latency: ready rises NREGS-1 rising edges after the first edge at which reset is sampled low. With NREGS=32, that is 31 edges.
- Write-to-read latency is one edge without bypass. A read in the same cycle as the write returns the old value.
- Reserve-to-busy latency is one edge. rsN_busy reflects a reservation from the following cycle onward.
- Both read ports are fully independent and may address the same register.

## Configuration
- REGFILE_BYPASS_EN defined: write-through forwarding in READY. If we=1, rd_addr≠0 and rd_addr==rsN_addr, then rsN_data=rd_data and rsN_busy=0 in the same cycle. A same-cycle reservation still takes effect at the edge.
- REGFILE_BYPASS_EN undefined: no forwarding. Reads return stored contents and current busy bits only.

## Test plan
- Clear sequence (NREGS=32): preload garbage via a previous run, pulse reset for 3 cycles → ready=0 for exactly 31 edges after reset deasserts, then every register reads 0 and all busy bits read 0. Reassert reset at clear edge 10 → sequence restarts and ready is delayed accordingly.
- Write/read, both ports: write 0xDEADBEEF to x5 and 0x12345678 to x31 → next cycle rs1_addr=5 gives 0xDEADBEEF, rs2_addr=31 gives 0x12345678. Write to x0 → x0 still reads 0.
- Scoreboard: reserve x7 → rs1_busy=1 next cycle. Write x7=0x55 → busy=0 and data 0x55 next cycle. Reserve x0 → busy stays 0.
- Simultaneous events: in one cycle, write x9=0xA and reserve x9 → next cycle data 0xA, busy=1. Write during CLEAR → ignored, register still reads 0 after ready.
- Bypass with REGFILE_BYPASS_EN: write x3=0xCAFE while busy[x3]=1 and rs1_addr=rs2_addr=3 → same cycle both ports give 0xCAFE with busy=0. Without the macro → same cycle returns the old value with busy=1, next cycle 0xCAFE with busy=0.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Register-file bus: decoder read/reserve ports plus writeback write port.
// The master drives addresses and requests; the slave (regfile_sb) returns data, busy bits and ready.
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic            ready;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            we;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;

    modport master (
        input  ready, rs1_data, rs2_data, rs1_busy, rs2_busy,
        output rs1_addr, rs2_addr, we, rd_addr, rd_data, rsv_en, rsv_addr
    );

    modport slave (
        output ready, rs1_data, rs2_data, rs1_busy, rs2_busy,
        input  rs1_addr, rs2_addr, we, rd_addr, rd_data, rsv_en, rsv_addr
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with per-register busy scoreboard and a post-reset clear sequencer.
// Optional REGFILE_BYPASS_EN adds same-cycle write-through forwarding on both read ports.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   CLEAR | zeroing reg[1..NREGS-1], one per edge; traffic ignored
//   READY | clear done; reads, writes and reservations accepted
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic         clk,
    input  logic         reset,
    regfile_sb_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state;
    logic [AW-1:0]     cnt;
    logic [XLEN-1:0]   regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic              ready_q;

    // reg[0] is never stored; reads of address 0 are masked to zero instead.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            cnt     <= AW'(1);
            busy    <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    regs[cnt] <= '0;
                    if (cnt == AW'(NREGS - 1)) begin
                        state   <= READY;
                        ready_q <= 1'b1;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                READY: begin
                    if (bus.we && bus.rd_addr != '0) begin
                        regs[bus.rd_addr] <= bus.rd_data;
                        busy[bus.rd_addr] <= 1'b0;
                    end
                    // Reservation after the release so a new producer wins a same-edge collision.
                    if (bus.rsv_en && bus.rsv_addr != '0) begin
                        busy[bus.rsv_addr] <= 1'b1;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    assign bus.ready = ready_q;

    always_comb begin
        bus.rs1_data = '0;
        bus.rs1_busy = 1'b0;
        bus.rs2_data = '0;
        bus.rs2_busy = 1'b0;
        if (state == READY) begin
            if (bus.rs1_addr != '0) begin
                bus.rs1_data = regs[bus.rs1_addr];
                bus.rs1_busy = busy[bus.rs1_addr];
            end
            if (bus.rs2_addr != '0) begin
                bus.rs2_data = regs[bus.rs2_addr];
                bus.rs2_busy = busy[bus.rs2_addr];
            end
`ifdef REGFILE_BYPASS_EN
            if (bus.we && bus.rd_addr != '0 && bus.rd_addr == bus.rs1_addr) begin
                bus.rs1_data = bus.rd_data;
                bus.rs1_busy = 1'b0;
            end
            if (bus.we && bus.rd_addr != '0 && bus.rd_addr == bus.rs2_addr) begin
                bus.rs2_data = bus.rd_data;
                bus.rs2_busy = 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues expected read/ready values per cycle,
// a monitor compares them on the falling edge of that cycle.
module tb_regfile_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();
    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              cyc;
        string           name;
        bit              chk_rd;
        logic [XLEN-1:0] d1;
        logic            b1;
        logic [XLEN-1:0] d2;
        logic            b2;
        logic            rdy;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic void cmp(string nm, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                exp_t e;
                e = q.pop_front();
                if (e.cyc < cyc) begin
                    n_total++;
                    $display("FAIL %s: check for cycle %0d missed at cycle %0d", e.name, e.cyc, cyc);
                end else begin
                    cmp({e.name, " ready"}, XLEN'(bus.ready), XLEN'(e.rdy));
                    if (e.chk_rd) begin
                        cmp({e.name, " rs1_data"}, bus.rs1_data, e.d1);
                        cmp({e.name, " rs1_busy"}, XLEN'(bus.rs1_busy), XLEN'(e.b1));
                        cmp({e.name, " rs2_data"}, bus.rs2_data, e.d2);
                        cmp({e.name, " rs2_busy"}, XLEN'(bus.rs2_busy), XLEN'(e.b2));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(string nm, bit chk, logic [XLEN-1:0] d1, logic b1,
                            logic [XLEN-1:0] d2, logic b2, logic rdy);
        exp_t e;
        e.cyc = cyc; e.name = nm; e.chk_rd = chk;
        e.d1 = d1; e.b1 = b1; e.d2 = d2; e.b2 = b2; e.rdy = rdy;
        q.push_back(e);
    endtask

    task automatic set_rd(int a1, int a2);
        bus.rs1_addr = AW'(a1);
        bus.rs2_addr = AW'(a2);
    endtask

    task automatic wr(bit en, int a, logic [XLEN-1:0] d);
        bus.we      = en;
        bus.rd_addr = AW'(a);
        bus.rd_data = d;
    endtask

    task automatic rsv(bit en, int a);
        bus.rsv_en   = en;
        bus.rsv_addr = AW'(a);
    endtask

    // Hold reset, release it, then expect ready exactly 31 edges later.
    // With junk set, a write and a reservation to x20 are held throughout the clear.
    task automatic clear_seq(int rst_cycles, bit junk);
        reset = 1'b1;
        wr(0, 0, '0);
        rsv(0, 0);
        set_rd(5, 12);
        for (int i = 0; i < rst_cycles; i++) begin
            step();
            push_exp("rst", 1, '0, 0, '0, 0, 0);
        end
        reset = 1'b0;
        if (junk) begin
            wr(1, 20, 32'hBAD0BAD0);
            rsv(1, 20);
            set_rd(20, 5);
        end
        for (int k = 1; k <= 31; k++) begin
            step();
            if (k == 31) begin
                wr(0, 0, '0);
                rsv(0, 0);
                push_exp("clr_done", 0, '0, 0, '0, 0, 1);
            end else begin
                push_exp("clr", 1, '0, 0, '0, 0, 0);
            end
        end
    endtask

    initial begin
        wr(0, 0, '0);
        rsv(0, 0);
        set_rd(0, 0);
        #1;
        clear_seq(2, 0);

        // Fill every register with garbage and scatter reservations over it.
        for (int i = 1; i < 32; i++) begin
            wr(1, i, 32'hA5A5A5A5 ^ (i * 32'h01010101));
            rsv(1, (i * 7) % 32);
            step();
        end
        wr(0, 0, '0);
        rsv(0, 0);
        set_rd(5, 31);
        push_exp("preload", 1, 32'hA0A0A0A0, 1, 32'hBABABABA, 0, 1);
        step();

        clear_seq(3, 0);
        for (int i = 0; i < 16; i++) begin
            set_rd(i, i + 16);
            push_exp("sweep", 1, '0, 0, '0, 0, 1);
            step();
        end

        // Reset reasserted at the 10th clear edge restarts the sequence.
        reset = 1'b1;
        step();
        push_exp("rst", 0, '0, 0, '0, 0, 0);
        reset = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            push_exp("restart_pre", 0, '0, 0, '0, 0, 0);
        end
        clear_seq(1, 1);
        set_rd(20, 0);
        push_exp("clr_write", 1, '0, 0, '0, 0, 1);
        step();

        set_rd(1, 2);
        wr(1, 5, 32'hDEADBEEF);
        push_exp("wr_other", 1, '0, 0, '0, 0, 1);
        step();
        wr(1, 31, 32'h12345678);
        step();
        wr(0, 0, '0);
        set_rd(5, 31);
        push_exp("wr_rd", 1, 32'hDEADBEEF, 0, 32'h12345678, 0, 1);
        step();
        wr(1, 0, 32'hFFFFFFFF);
        set_rd(0, 0);
        push_exp("wr_x0_same", 1, '0, 0, '0, 0, 1);
        step();
        wr(0, 0, '0);
        push_exp("wr_x0", 1, '0, 0, '0, 0, 1);
        step();

        rsv(1, 7);
        set_rd(7, 7);
        push_exp("rsv_same", 1, '0, 0, '0, 0, 1);
        step();
        rsv(0, 0);
        push_exp("rsv_next", 1, '0, 1, '0, 1, 1);
        step();
        wr(1, 7, 32'h55);
        set_rd(7, 8);
        push_exp("rel_same", 1, BYP ? 32'h55 : 32'h0, !BYP, '0, 0, 1);
        step();
        wr(0, 0, '0);
        push_exp("rel_next", 1, 32'h55, 0, '0, 0, 1);
        step();
        rsv(1, 0);
        set_rd(0, 7);
        step();
        rsv(0, 0);
        push_exp("rsv_x0", 1, '0, 0, 32'h55, 0, 1);
        step();

        wr(1, 9, 32'hA);
        rsv(1, 9);
        set_rd(1, 2);
        step();
        wr(0, 0, '0);
        set_rd(9, 9);
        push_exp("wr_rsv", 1, 32'hA, 1, 32'hA, 1, 1);
        step();
        rsv(0, 0);
        push_exp("rsv_busy", 1, 32'hA, 1, 32'hA, 1, 1);
        step();
        wr(1, 10, 32'h3);
        set_rd(1, 2);
        step();
        wr(0, 0, '0);
        set_rd(10, 10);
        push_exp("wr_free", 1, 32'h3, 0, 32'h3, 0, 1);
        step();

        rsv(1, 3);
        set_rd(1, 2);
        step();
        rsv(0, 0);
        wr(1, 3, 32'hCAFE);
        set_rd(3, 3);
        push_exp("byp_same", 1, BYP ? 32'hCAFE : 32'h0, !BYP, BYP ? 32'hCAFE : 32'h0, !BYP, 1);
        step();
        wr(0, 0, '0);
        push_exp("byp_next", 1, 32'hCAFE, 0, 32'hCAFE, 0, 1);
        step();

        step();
        step();
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d checks left unserviced, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
